// File: rtl/rand_matrix_collector.sv
`default_nettype none
// rand_matrix_collector: buffers one m x n matrix from the generator and replays it row-major
// on a valid/ready stream. Optional macro RANGE_CHECK_EN clamps elements to [elem_min, elem_max].
module rand_matrix_collector #(
    parameter int MAX_ELEMS = 25,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_start,
    input  logic              cap_abort,
    input  logic [2:0]        dim_m,
    input  logic [2:0]        dim_n,
    input  logic              elem_valid,
    input  logic [DATA_W-1:0] elem_data,
    input  logic [7:0]        elem_min,
    input  logic [7:0]        elem_max,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_row,
    output logic [2:0]        out_col,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              ovf_err,
    output logic              range_err
);
    localparam int         c_idx_w     = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
    localparam logic [5:0] c_max_total = 6'(MAX_ELEMS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_COMMIT  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        total_q, total_d;
    logic [2:0]        dim_n_q, dim_n_d;
    logic [5:0]        wr_ptr_q, wr_ptr_d;
    logic [5:0]        rd_ptr_q, rd_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [2:0]        out_row_q, out_row_d;
    logic [2:0]        out_col_q, out_col_d;
    logic              out_last_q, out_last_d;
    logic              cfg_err_q, cfg_err_d;
    logic              ovf_err_q, ovf_err_d;
    logic              range_err_q, range_err_d;

    logic [DATA_W-1:0] buf_q [MAX_ELEMS];
    logic              w_buf_we;
    logic [DATA_W-1:0] w_wdata;
    logic              w_range_hit;
    logic [5:0]        w_total_req;
    logic [5:0]        w_rd_next;

    assign w_total_req = 6'(dim_m) * 6'(dim_n);
    assign w_rd_next   = rd_ptr_q + 6'd1;

`ifdef RANGE_CHECK_EN
    logic [DATA_W-1:0] w_lo, w_hi;
    assign w_lo = DATA_W'(elem_min);
    assign w_hi = DATA_W'(elem_max);

    // An inverted window disables clamping but still flags every beat.
    always_comb begin
        w_wdata     = elem_data;
        w_range_hit = 1'b0;
        if (w_lo > w_hi) begin
            w_range_hit = 1'b1;
        end else if (elem_data < w_lo) begin
            w_wdata     = w_lo;
            w_range_hit = 1'b1;
        end else if (elem_data > w_hi) begin
            w_wdata     = w_hi;
            w_range_hit = 1'b1;
        end
    end
`else
    logic unused_range;
    assign unused_range = ^{elem_min, elem_max};
    assign w_wdata      = elem_data;
    assign w_range_hit  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        dim_n_d     = dim_n_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        cfg_err_d   = 1'b0;
        ovf_err_d   = ovf_err_q;
        range_err_d = range_err_q;
        w_buf_we    = 1'b0;

        if (cap_abort) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            wr_ptr_d    = 6'd0;
            rd_ptr_d    = 6'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cap_start) begin
                        if (w_total_req == 6'd0 || w_total_req > c_max_total) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            state_d     = S_CAPTURE;
                            total_d     = w_total_req;
                            dim_n_d     = dim_n;
                            wr_ptr_d    = 6'd0;
                            ovf_err_d   = 1'b0;
                            range_err_d = 1'b0;
                        end
                    end
                    if (elem_valid) ovf_err_d = 1'b1;
                end
                S_CAPTURE: begin
                    if (elem_valid) begin
                        w_buf_we    = 1'b1;
                        wr_ptr_d    = wr_ptr_q + 6'd1;
                        range_err_d = range_err_q | w_range_hit;
                        if (wr_ptr_q == total_q - 6'd1) begin
                            // Single-element matrix: buffer write lands this edge, so forward it.
                            state_d     = S_COMMIT;
                            rd_ptr_d    = 6'd0;
                            out_valid_d = 1'b1;
                            out_data_d  = (total_q == 6'd1) ? w_wdata : buf_q[0];
                            out_row_d   = 3'd0;
                            out_col_d   = 3'd0;
                            out_last_d  = (total_q == 6'd1);
                        end
                    end
                end
                S_COMMIT: begin
                    if (elem_valid) ovf_err_d = 1'b1;
                    if (out_valid_q && out_ready) begin
                        if (out_last_q) begin
                            state_d     = S_DONE;
                            out_valid_d = 1'b0;
                        end else begin
                            rd_ptr_d   = w_rd_next;
                            out_data_d = buf_q[w_rd_next[c_idx_w-1:0]];
                            out_last_d = (w_rd_next == total_q - 6'd1);
                            if (out_col_q == dim_n_q - 3'd1) begin
                                out_col_d = 3'd0;
                                out_row_d = out_row_q + 3'd1;
                            end else begin
                                out_col_d = out_col_q + 3'd1;
                            end
                        end
                    end
                end
                default: begin
                    if (elem_valid) ovf_err_d = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            total_q     <= 6'd0;
            dim_n_q     <= 3'd0;
            wr_ptr_q    <= 6'd0;
            rd_ptr_q    <= 6'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= 3'd0;
            out_col_q   <= 3'd0;
            out_last_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            dim_n_q     <= dim_n_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            cfg_err_q   <= cfg_err_d;
            ovf_err_q   <= ovf_err_d;
            range_err_q <= range_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) buf_q[wr_ptr_q[c_idx_w-1:0]] <= w_wdata;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == S_CAPTURE) || (state_q == S_COMMIT);
    assign done      = (state_q == S_DONE);
    assign cfg_err   = cfg_err_q;
    assign ovf_err   = ovf_err_q;
    assign range_err = range_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rand_matrix_collector.sv
`default_nettype none
// Directed self-checking bench for rand_matrix_collector; expectations hand-computed.
module tb_rand_matrix_collector;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cap_start = 1'b0, cap_abort = 1'b0;
    logic [2:0] dim_m = 3'd0, dim_n = 3'd0;
    logic       elem_valid = 1'b0;
    logic [7:0] elem_data = 8'd0, elem_min = 8'd0, elem_max = 8'd0;
    logic       out_valid, out_ready = 1'b1;
    logic [7:0] out_data;
    logic [2:0] out_row, out_col;
    logic       out_last, busy, done, cfg_err, ovf_err, range_err;

    int checks = 0;
    int failures = 0;

    rand_matrix_collector #(.MAX_ELEMS(25), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cap_start(cap_start), .cap_abort(cap_abort),
        .dim_m(dim_m), .dim_n(dim_n), .elem_valid(elem_valid), .elem_data(elem_data),
        .elem_min(elem_min), .elem_max(elem_max), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .busy(busy), .done(done), .cfg_err(cfg_err), .ovf_err(ovf_err), .range_err(range_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [2:0] m, input logic [2:0] n);
        cap_start = 1'b1; dim_m = m; dim_n = n;
        step();
        cap_start = 1'b0;
    endtask

    initial begin
        logic [9:0] pat;
        int h;
        logic [7:0] rbeats [3];
        logic [7:0] rexp [3];

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_errs", 32'({cfg_err, ovf_err, range_err, out_last}), 0);
        rst_n = 1'b1;
        step();

        // 2x3 matrix, back-to-back beats, ready held high
        start(3'd2, 3'd3);
        chk("t1_busy", 32'(busy), 1);
        for (int i = 0; i < 6; i++) begin
            elem_valid = 1'b1; elem_data = 8'(10 + i);
            step();
        end
        elem_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            chk("t1_valid", 32'(out_valid), 1);
            chk("t1_data", 32'(out_data), 32'(10 + j));
            chk("t1_row", 32'(out_row), 32'(j / 3));
            chk("t1_col", 32'(out_col), 32'(j % 3));
            chk("t1_last", 32'(out_last), 32'(j == 5));
            chk("t1_nodone", 32'(done), 0);
            step();
        end
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_done", 32'(busy), 0);
        chk("t1_valid_off", 32'(out_valid), 0);
        step();
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_ovf", 32'(ovf_err), 0);

        // 1x1 matrix: element forwarded on the very next cycle
        start(3'd1, 3'd1);
        elem_valid = 1'b1; elem_data = 8'h5A;
        step();
        elem_valid = 1'b0;
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_data", 32'(out_data), 32'h5A);
        chk("t2_last", 32'(out_last), 1);
        step();
        chk("t2_done", 32'(done), 1);
        step();

        // Rejected dimensions
        start(3'd0, 3'd4);
        chk("t3a_cfg", 32'(cfg_err), 1);
        chk("t3a_busy", 32'(busy), 0);
        step();
        chk("t3a_cfg_pulse", 32'(cfg_err), 0);
        start(3'd6, 3'd5);
        chk("t3b_cfg", 32'(cfg_err), 1);
        chk("t3b_busy", 32'(busy), 0);
        step();
        chk("t3b_cfg_pulse", 32'(cfg_err), 0);

        // 2x2 with stalls and one surplus beat during replay
        start(3'd2, 3'd2);
        for (int i = 0; i < 4; i++) begin
            elem_valid = 1'b1; elem_data = 8'(8'h21 + i);
            step();
        end
        elem_valid = 1'b0;
        pat = 10'b1001001001;
        h = 0;
        for (int c = 0; c < 10; c++) begin
            out_ready  = pat[c];
            elem_valid = (c == 1);
            elem_data  = 8'hFF;
            chk("t4_valid", 32'(out_valid), 1);
            chk("t4_data", 32'(out_data), 32'(8'h21 + h));
            chk("t4_rowcol", 32'({out_row, out_col}), 32'({3'(h / 2), 3'(h % 2)}));
            chk("t4_last", 32'(out_last), 32'(h == 3));
            step();
            if (pat[c]) h++;
        end
        elem_valid = 1'b0; out_ready = 1'b1;
        chk("t4_handshakes", 32'(h), 4);
        chk("t4_done", 32'(done), 1);
        chk("t4_ovf", 32'(ovf_err), 1);
        step();

        // Abort mid-capture, then a fresh 1x2 matrix
        start(3'd3, 3'd3);
        chk("t5_ovf_cleared", 32'(ovf_err), 0);
        for (int i = 0; i < 3; i++) begin
            elem_valid = 1'b1; elem_data = 8'(1 + i);
            step();
        end
        elem_valid = 1'b0;
        cap_abort = 1'b1;
        step();
        cap_abort = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_quiet", 32'({out_valid, done}), 0);
            step();
        end
        start(3'd1, 3'd2);
        elem_valid = 1'b1; elem_data = 8'd7; step();
        elem_data = 8'd8; step();
        elem_valid = 1'b0;
        chk("t5_d0", 32'({out_valid, out_data, out_col, out_last}), 32'({1'b1, 8'd7, 3'd0, 1'b0}));
        step();
        chk("t5_d1", 32'({out_valid, out_data, out_col, out_last}), 32'({1'b1, 8'd8, 3'd1, 1'b1}));
        step();
        chk("t5_done", 32'(done), 1);
        step();

        // Range window 20..40
        elem_min = 8'd20; elem_max = 8'd40;
        rbeats[0] = 8'd5; rbeats[1] = 8'd30; rbeats[2] = 8'd50;
`ifdef RANGE_CHECK_EN
        rexp[0] = 8'd20; rexp[1] = 8'd30; rexp[2] = 8'd40;
`else
        rexp[0] = 8'd5; rexp[1] = 8'd30; rexp[2] = 8'd50;
`endif
        start(3'd1, 3'd3);
        for (int i = 0; i < 3; i++) begin
            elem_valid = 1'b1; elem_data = rbeats[i];
            step();
        end
        elem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_data", 32'(out_data), 32'(rexp[i]));
            step();
        end
`ifdef RANGE_CHECK_EN
        chk("t6_range_err", 32'(range_err), 1);
`else
        chk("t6_range_err", 32'(range_err), 0);
`endif
        chk("t6_done", 32'(done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rand_matrix_collector.md
Name: rand_matrix_collector

Overview:
Sits directly downstream of the random matrix generator. Captures its per-element byte stream into an internal row-major buffer sized for one matrix. Once the matrix is complete, replays it to matrix storage over a valid/ready stream tagged with row/col indices and a last flag. Also flags bad dimensions and surplus elements.

Parameters:
MAX_ELEMS, 25, buffer depth in elements; m*n above this is rejected
DATA_W, 8, element width in bits

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cap_start  in  1  start-capture pulse; sampled only in IDLE
cap_abort  in  1  abandon current matrix; highest priority
dim_m  in  3  row count, latched on accepted cap_start
dim_n  in  3  column count, latched on accepted cap_start
elem_valid  in  1  elem_data carries one element this cycle
elem_data  in  DATA_W  element value
elem_min  in  8  lower bound (used only with RANGE_CHECK_EN)
elem_max  in  8  upper bound (used only with RANGE_CHECK_EN)
out_valid  out  1  out_* fields hold a valid element
out_ready  in  1  storage accepts the element
out_data  out  DATA_W  element value
out_row  out  3  row index, 0-based
out_col  out  3  column index, 0-based
out_last  out  1  high on the final element of the matrix
busy  out  1  high in CAPTURE or COMMIT
done  out  1  one-cycle pulse after the last handshake
cfg_err  out  1  one-cycle pulse on a rejected cap_start
ovf_err  out  1  sticky: an element arrived outside CAPTURE
range_err  out  1  sticky: an element was out of range

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; pointers 0.
  - All outputs 0.
  - Buffer contents don't-care.
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- total = dim_m*dim_n, 6-bit unsigned product; latched with the dims on an accepted cap_start.
- States: IDLE, CAPTURE, COMMIT, DONE.
- IDLE:
  - On cap_start with total==0 or total>MAX_ELEMS: cfg_err=1 for one cycle; stay IDLE.
  - Otherwise: go to CAPTURE, busy=1, wr_ptr=0.
  - Accepted cap_start also clears ovf_err and range_err.
- CAPTURE:
  - Each elem_valid writes buf[wr_ptr] and increments wr_ptr.
  - Beat with wr_ptr==total-1 goes to COMMIT on the next edge.
  - cap_start is ignored.
- COMMIT entry (cycle after the last capture beat):
  - out_valid=1, out_data=buf[0], out_row=0, out_col=0, out_last=(total==1).
  - For total==1, the element written in the last capture cycle is forwarded.
- COMMIT:
  - Handshake = out_valid & out_ready.
  - While out_ready=0, all out_* hold stable.
  - On handshake, advance rd_ptr. col increments; at dim_n-1 it wraps to 0 and row increments.
  - out_last=1 exactly when rd_ptr==total-1.
  - Handshake with out_last=1: go to DONE, out_valid=0 the next cycle.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A cap_start during DONE is ignored.
- elem_valid in IDLE, COMMIT or DONE: element dropped, ovf_err=1 (sticky). Surplus beats never overwrite the buffer.
- cap_abort in any state:
  - Next edge: IDLE, out_valid=0, busy=0, no done.
  - Sticky errors are kept.
  - Abort wins over cap_start in the same cycle.
- Latency: the last element is accepted at edge k; out_valid rises at edge k+1. Best case is total+1 cycles from the last capture beat to done, with out_ready tied 1.

Optional Feature:
RANGE_CHECK_EN
- Defined: during CAPTURE, an element below elem_min is stored as elem_min, and one above elem_max is stored as elem_max. Either case sets range_err (sticky).
- If elem_min>elem_max, no clamping is done and range_err is set on every beat.
- Undefined: elements are stored unmodified, range_err is tied 0, and elem_min/elem_max are unused.

Test Plan:
- m=2,n=3, six beats 10..15 back-to-back, out_ready=1 -> out stream 10..15 with (row,col) (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); out_last only on 15; done one cycle after; ovf_err=0.
- m=1,n=1, single beat 0x5A -> out_valid the next cycle with out_data=0x5A, out_last=1; done follows the handshake.
- m=0,n=4 cap_start -> cfg_err pulse of one cycle, busy stays 0. Same with m=6,n=5 (30>25).
- m=2,n=2, out_ready toggling 1,0,0,1,... -> out_* stable during stalls, exactly 4 handshakes, then done. A fifth elem_valid during COMMIT -> ovf_err=1, stream unchanged.
- cap_abort after 3 of 9 beats (m=n=3) -> IDLE next cycle, no out_valid or done. A new cap_start m=1,n=2 with beats 7,8 -> outputs 7,8.
- RANGE_CHECK_EN, min=20, max=40, beats 5,30,50 (m=1,n=3) -> outputs 20,30,40, range_err=1. Without the macro -> outputs 5,30,50, range_err=0.
